// File: rtl/cl_unpacker.sv
// Cache-line unpacker: pops 512-bit lines from a show-ahead DMA read FIFO and
// streams them out least-significant word first on a valid/ready interface.
module cl_unpacker #(
  parameter int CL_DATA_WIDTH = 512,
  parameter int WORD_WIDTH    = 32,
  parameter int COUNT_WIDTH   = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic [COUNT_WIDTH-1:0]   num_lines,
  input  logic                     dma_empty,
  input  logic [CL_DATA_WIDTH-1:0] dma_rd_data,
  output logic                     dma_rd_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int WPL   = CL_DATA_WIDTH / WORD_WIDTH;
  localparam int IDX_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CL_DATA_WIDTH-1:0] r_line;
  logic                     r_buf_valid;
  logic [IDX_W-1:0]         r_word_idx;
  logic [COUNT_WIDTH-1:0]   r_lines_left;

  logic                     w_xfer;
  logic                     w_at_last_word;
  logic                     w_lines_zero;
  logic                     w_start;
  logic                     w_rd_en;
  logic [WORD_WIDTH-1:0]    w_words [WPL];

  always_comb begin
    for (int k = 0; k < WPL; k++) begin
      w_words[k] = r_line[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  assign w_at_last_word = (r_word_idx == LAST_IDX);
  assign w_lines_zero   = (r_lines_left == '0);
  assign w_xfer         = r_buf_valid && out_ready;
  assign w_start        = go && (r_state != S_ACTIVE);

  // Data is gated so the bus reads zero whenever no word is held.
  assign out_valid = r_buf_valid;
  assign out_data  = r_buf_valid ? w_words[r_word_idx] : '0;
  assign out_last  = r_buf_valid && w_lines_zero && w_at_last_word;
  assign dma_rd_en = w_rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (go) begin
          w_state_nxt = (num_lines == '0) ? S_DONE : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        busy = 1'b1;
        // Refill as the last word leaves so consecutive lines stream without a bubble.
        w_rd_en = !rst && !w_lines_zero && !dma_empty &&
                  (!r_buf_valid || (w_xfer && w_at_last_word));
        if (w_xfer && out_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_valid  <= 1'b0;
      r_word_idx   <= '0;
      r_lines_left <= '0;
    end else if (w_start) begin
      r_buf_valid  <= 1'b0;
      r_word_idx   <= '0;
      r_lines_left <= num_lines;
    end else if (w_rd_en) begin
      r_buf_valid  <= 1'b1;
      r_word_idx   <= '0;
      r_lines_left <= r_lines_left - COUNT_WIDTH'(1);
    end else if (w_xfer) begin
      if (w_at_last_word) begin
        r_buf_valid <= 1'b0;
      end else begin
        r_word_idx <= r_word_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_en) begin
      r_line <= dma_rd_data;
    end
  end

endmodule

// File: tb/tb_cl_unpacker.sv
// Directed bench for cl_unpacker: FIFO model feeds lines, a word scoreboard
// holds the expected stream, and each output word is checked as it appears.
module tb_cl_unpacker;

  localparam int WPL = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         go;
  logic [64:0]  num_lines;
  logic         dma_empty;
  logic [511:0] dma_rd_data;
  logic         dma_rd_en;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  cl_unpacker dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .num_lines   (num_lines),
    .dma_empty   (dma_empty),
    .dma_rd_data (dma_rd_data),
    .dma_rd_en   (dma_rd_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  initial forever #5 clk = ~clk;

  logic [511:0] fifo [$];
  logic [32:0]  sb [$];
  int n_vec = 0;
  int n_err = 0;
  int rd_cnt, xfer_cnt, bad_pop, gaps, cyc;
  bit seen_valid, track_gap, bp_mode, prev_last_xfer;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd_dma();
    dma_empty   = (fifo.size() == 0);
    dma_rd_data = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  task automatic push_line(input logic [31:0] base, input bit last_line);
    logic [511:0] l;
    for (int k = 0; k < WPL; k++) begin
      l[k*32 +: 32] = base + 32'(k);
      sb.push_back({last_line && (k == WPL - 1), base + 32'(k)});
    end
    fifo.push_back(l);
    upd_dma();
  endtask

  task automatic clear_stats();
    rd_cnt = 0; xfer_cnt = 0; bad_pop = 0; gaps = 0;
    seen_valid = 0; prev_last_xfer = 0;
  endtask

  // One clock: sample at the falling edge, update FIFO model after the rising edge.
  task automatic cycle();
    bit s_rd, s_xfer;
    @(negedge clk);
    s_rd   = dma_rd_en;
    s_xfer = out_valid && out_ready;
    if (s_rd) begin
      rd_cnt++;
      check("rd_en_while_empty", 64'(dma_empty), 64'(0));
      if (out_valid && !(s_xfer && (xfer_cnt % WPL == WPL - 1))) bad_pop++;
    end
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("extra_word_valid", 64'(out_valid), 64'(0));
      end else begin
        check("word_data", 64'(out_data), 64'(sb[0][31:0]));
        check("word_last", 64'(out_last), 64'(sb[0][32]));
      end
      seen_valid = 1;
    end else if (track_gap && seen_valid && sb.size() != 0) begin
      gaps++;
    end
    if (s_xfer) begin
      if (sb.size() != 0) sb.delete(0);
      xfer_cnt++;
    end
    prev_last_xfer = s_xfer && out_last;
    @(posedge clk);
    #1;
    if (s_rd && fifo.size() != 0) fifo.delete(0);
    upd_dma();
    cyc++;
    if (bp_mode) out_ready = (cyc % 3 == 0);
  endtask

  task automatic do_go(input logic [64:0] n);
    go = 1'b1;
    num_lines = n;
    cycle();
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      cycle();
      n++;
    end
    check("done_set", 64'(done), 64'(1));
    check("done_right_after_last", 64'(prev_last_xfer), 64'(1));
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"}, 64'(dma_rd_en), 64'(0));
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_last"},  64'(out_last),  64'(0));
    check({tag, "_busy"},  64'(busy),      64'(0));
    check({tag, "_done"},  64'(done),      64'(0));
    check({tag, "_data"},  64'(out_data),  64'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1; go = 1'b0; num_lines = '0; out_ready = 1'b1;
    bp_mode = 0; track_gap = 0; cyc = 0;
    clear_stats();
    upd_dma();
    repeat (3) cycle();
    check_zero("reset");
    rst = 1'b0;
    cycle();

    // Zero lines: a line sits in the FIFO but must not be popped.
    fifo.push_back({16{32'hDEAD_BEEF}});
    upd_dma();
    clear_stats();
    do_go(65'd0);
    check("zero_done", 64'(done), 64'(1));
    check("zero_busy", 64'(busy), 64'(0));
    repeat (3) cycle();
    check("zero_no_rd", 64'(rd_cnt), 64'(0));
    check("zero_no_valid", 64'(seen_valid), 64'(0));
    fifo.delete();
    upd_dma();

    // Single line, words 0..F.
    clear_stats();
    push_line(32'h0, 1);
    do_go(65'd1);
    check("single_busy", 64'(busy), 64'(1));
    check("single_done_low", 64'(done), 64'(0));
    wait_done(60);
    check("single_rd_cnt", 64'(rd_cnt), 64'(1));
    check("single_words", 64'(xfer_cnt), 64'(16));

    // Back-to-back lines with the FIFO pre-filled.
    clear_stats();
    track_gap = 1;
    for (int i = 0; i < 4; i++) push_line(32'h100 * 32'(i + 1), i == 3);
    do_go(65'd4);
    wait_done(200);
    track_gap = 0;
    check("b2b_rd_cnt", 64'(rd_cnt), 64'(4));
    check("b2b_words", 64'(xfer_cnt), 64'(64));
    check("b2b_gaps", 64'(gaps), 64'(0));
    check("b2b_pop_align", 64'(bad_pop), 64'(0));

    // Backpressure, ready high one cycle in three.
    clear_stats();
    push_line(32'hA000_0000, 0);
    push_line(32'hA000_0010, 1);
    bp_mode = 1;
    do_go(65'd2);
    wait_done(300);
    bp_mode = 0;
    out_ready = 1'b1;
    check("bp_words", 64'(xfer_cnt), 64'(32));
    check("bp_rd_cnt", 64'(rd_cnt), 64'(2));

    // Starved DMA between two lines.
    clear_stats();
    push_line(32'h300, 0);
    do_go(65'd2);
    n = 0;
    while (xfer_cnt < 16 && n < 100) begin cycle(); n++; end
    check("starve_first_line", 64'(xfer_cnt), 64'(16));
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("starve_valid_low", 64'(out_valid), 64'(0));
      check("starve_busy", 64'(busy), 64'(1));
    end
    check("starve_rd_cnt", 64'(rd_cnt), 64'(1));
    push_line(32'h310, 1);
    wait_done(60);
    check("starve_rd_total", 64'(rd_cnt), 64'(2));
    check("starve_words", 64'(xfer_cnt), 64'(32));

    // Reset after word 7 of line 2 of 3, then a clean single-line run.
    clear_stats();
    for (int i = 0; i < 3; i++) push_line(32'h400 + 32'h10 * 32'(i), i == 2);
    do_go(65'd3);
    n = 0;
    while (xfer_cnt < 24 && n < 100) begin cycle(); n++; end
    check("rst_mid_words", 64'(xfer_cnt), 64'(24));
    out_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_zero("rst_mid");
    sb.delete();
    fifo.delete();
    upd_dma();
    out_ready = 1'b1;
    clear_stats();
    push_line(32'h500, 1);
    do_go(65'd1);
    wait_done(60);
    check("rerun_words", 64'(xfer_cnt), 64'(16));
    check("rerun_rd_cnt", 64'(rd_cnt), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
